// File: rtl/fifo_top_param.sv
// Bus-mapped parametrised FIFO peripheral: STATUS/DATA/CTRL/COUNT registers,
// sticky error bits, flush command and level/error interrupt.
module fifo_top_param #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter logic [7:0]  BASE   = 8'h20,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sel,
    input  logic              wr,
    input  logic [7:0]        address,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  fifo_cnt,
    output logic [7:0]        fifo_flag,
    output logic              irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_err_q, rd_err_d, rd_ack_q, rd_ack_d;
    logic              wr_err_q, wr_err_d, wr_ack_q, wr_ack_d;
    logic              sticky_rd_q, sticky_rd_d, sticky_wr_q, sticky_wr_d;
    logic              irq_en_q, irq_en_d;
    logic [CNT_W-1:0]  thr_q, thr_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [7:0]        fifo_flag_q, fifo_flag_d;

    logic [7:0]        off;
    logic              acc;
    logic              full_cur, empty_cur, af_cur;
    logic              full_nxt, empty_nxt, af_nxt, ae_nxt;
    logic [DATA_W-1:0] status_cur, ctrl_cur, rdata;

    // Register decode, FIFO bookkeeping and next-state of all outputs
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_err_d    = 1'b0;
        rd_ack_d    = 1'b0;
        wr_err_d    = 1'b0;
        wr_ack_d    = 1'b0;
        sticky_rd_d = sticky_rd_q;
        sticky_wr_d = sticky_wr_q;
        irq_en_d    = irq_en_q;
        thr_d       = thr_q;
        mem_we      = 1'b0;
        rdata       = '0;

        off       = 8'(address - BASE);
        acc       = sel && (off[7:2] == 6'd0);
        full_cur  = (count_q == CNT_W'(DEPTH));
        empty_cur = (count_q == '0);
        af_cur    = (thr_q != '0) && (count_q >= thr_q);

        status_cur     = '0;
        status_cur[0]  = rd_err_q;
        status_cur[1]  = rd_ack_q;
        status_cur[2]  = wr_err_q;
        status_cur[3]  = wr_ack_q;
        status_cur[4]  = empty_cur;
        status_cur[5]  = full_cur;
        status_cur[6]  = af_cur;
        status_cur[7]  = (count_q == CNT_W'(1));
        status_cur[8]  = sticky_rd_q;
        status_cur[9]  = sticky_wr_q;
        status_cur[10] = irq_q;

        ctrl_cur              = '0;
        ctrl_cur[1]           = irq_en_q;
        ctrl_cur[8 +: CNT_W]  = thr_q;

        if (acc) begin
            case (off[1:0])
                2'd0: begin
                    if (!wr) begin
                        rdata       = status_cur;
                        sticky_rd_d = 1'b0;
                        sticky_wr_d = 1'b0;
                    end
                end
                2'd1: begin
                    if (wr) begin
                        if (!full_cur) begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                            count_d  = count_q + CNT_W'(1);
                            wr_ack_d = 1'b1;
                        end else begin
                            wr_err_d    = 1'b1;
                            sticky_wr_d = 1'b1;
                        end
                    end else begin
                        if (!empty_cur) begin
                            rdata    = mem_q[rd_ptr_q];
                            rd_ptr_d = rd_ptr_q + PTR_W'(1);
                            count_d  = count_q - CNT_W'(1);
                            rd_ack_d = 1'b1;
                        end else begin
                            rd_err_d    = 1'b1;
                            sticky_rd_d = 1'b1;
                        end
                    end
                end
                2'd2: begin
                    if (wr) begin
                        if (din[0]) begin
                            wr_ptr_d = '0;
                            rd_ptr_d = '0;
                            count_d  = '0;
                        end
                        irq_en_d = din[1];
                        thr_d    = din[8 +: CNT_W];
                    end else begin
                        rdata = ctrl_cur;
                    end
                end
                default: begin
                    if (!wr) rdata = DATA_W'(count_q);
                end
            endcase
        end

        // Post-access view used by the gated outputs and the interrupt
        full_nxt  = (count_d == CNT_W'(DEPTH));
        empty_nxt = (count_d == '0);
        af_nxt    = (thr_d != '0) && (count_d >= thr_d);
        ae_nxt    = (count_d == CNT_W'(1));
        irq_d     = irq_en_d && (af_nxt || sticky_rd_d || sticky_wr_d);

        dout_d      = (acc && !wr) ? rdata : '0;
        fifo_cnt_d  = acc ? count_d : '0;
        fifo_flag_d = acc ? {ae_nxt, af_nxt, full_nxt, empty_nxt,
                             wr_ack_d, wr_err_d, rd_ack_d, rd_err_d} : 8'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_err_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            sticky_rd_q <= 1'b0;
            sticky_wr_q <= 1'b0;
            irq_en_q    <= 1'b0;
            thr_q       <= '0;
            irq_q       <= 1'b0;
            dout_q      <= '0;
            fifo_cnt_q  <= '0;
            fifo_flag_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_err_q    <= rd_err_d;
            rd_ack_q    <= rd_ack_d;
            wr_err_q    <= wr_err_d;
            wr_ack_q    <= wr_ack_d;
            sticky_rd_q <= sticky_rd_d;
            sticky_wr_q <= sticky_wr_d;
            irq_en_q    <= irq_en_d;
            thr_q       <= thr_d;
            irq_q       <= irq_d;
            dout_q      <= dout_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_flag_q <= fifo_flag_d;
        end
    end

    // Storage has no reset; flush only moves pointers
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= din;
    end

    assign dout      = dout_q;
    assign fifo_cnt  = fifo_cnt_q;
    assign fifo_flag = fifo_flag_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_fifo_top_param.sv
// Scoreboard bench for fifo_top_param (DEPTH=4, DATA_W=32, BASE=0x20) driven by
// a behavioural queue model of the register map.
module tb_fifo_top_param;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 4;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sel = 1'b0;
    logic          wr = 1'b0;
    logic [7:0]    address = 8'h00;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic [CW-1:0] fifo_cnt;
    logic [7:0]    fifo_flag;
    logic          irq;

    fifo_top_param #(.DATA_W(DW), .DEPTH(DP), .BASE(8'h20)) dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .wr(wr), .address(address),
        .din(din), .dout(dout), .fifo_cnt(fifo_cnt), .fifo_flag(fifo_flag), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   dout;
        logic [CW-1:0] cnt;
        logic [7:0]    flag;
        logic          irq;
        int            idx;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mq[$];
    bit          srd, swr, m_irq_en, m_irq;
    bit          m_rde, m_rda, m_wre, m_wra;
    logic [2:0]  m_thr;
    int          step = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic check_pending();
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val($sformatf("dout#%0d", e.idx), dout, e.dout);
            check_val($sformatf("cnt#%0d", e.idx), 32'(fifo_cnt), 32'(e.cnt));
            check_val($sformatf("flag#%0d", e.idx), 32'(fifo_flag), 32'(e.flag));
            check_val($sformatf("irq#%0d", e.idx), 32'(irq), 32'(e.irq));
        end
    endtask

    task automatic model_reset();
        mq.delete();
        srd = 0; swr = 0; m_irq_en = 0; m_irq = 0; m_thr = '0;
        m_rde = 0; m_rda = 0; m_wre = 0; m_wra = 0;
    endtask

    // One bus cycle: check the previous cycle's outputs, drive, update model
    task automatic cyc(input bit s, input bit w, input logic [7:0] a, input logic [31:0] d);
        exp_t        e;
        int          n;
        bit          inr, af;
        logic [31:0] r, pre;
        @(negedge clk);
        check_pending();
        sel = s; wr = w; address = a; din = d;
        n   = mq.size();
        inr = s && (a >= 8'h20) && (a <= 8'h23);
        pre = '0;
        pre[0] = m_rde; pre[1] = m_rda; pre[2] = m_wre; pre[3] = m_wra;
        pre[4] = (n == 0); pre[5] = (n == DP);
        pre[6] = (m_thr != 0) && (n >= int'(m_thr));
        pre[7] = (n == 1); pre[8] = srd; pre[9] = swr; pre[10] = m_irq;
        r = '0;
        m_rde = 0; m_rda = 0; m_wre = 0; m_wra = 0;
        if (inr) begin
            case (a[1:0])
                2'd0: if (!w) begin r = pre; srd = 0; swr = 0; end
                2'd1: begin
                    if (w) begin
                        if (n < DP) begin mq.push_back(d); m_wra = 1; end
                        else begin m_wre = 1; swr = 1; end
                    end else begin
                        if (n > 0) begin r = mq.pop_front(); m_rda = 1; end
                        else begin m_rde = 1; srd = 1; end
                    end
                end
                2'd2: begin
                    if (w) begin
                        if (d[0]) mq.delete();
                        m_irq_en = d[1];
                        m_thr    = d[10:8];
                    end else begin
                        r = (32'(m_thr) << 8) | (32'(m_irq_en) << 1);
                    end
                end
                default: if (!w) r = 32'(n);
            endcase
        end
        n     = mq.size();
        af    = (m_thr != 0) && (n >= int'(m_thr));
        m_irq = m_irq_en && (af || srd || swr);
        e.dout = (inr && !w) ? r : 32'h0;
        e.cnt  = inr ? CW'(n) : '0;
        e.flag = inr ? {(n == 1), af, (n == DP), (n == 0), m_wra, m_wre, m_rda, m_rde} : 8'h0;
        e.irq  = m_irq;
        e.idx  = step;
        step++;
        sbq.push_back(e);
    endtask

    task automatic push(input logic [31:0] d); cyc(1, 1, 8'h21, d); endtask
    task automatic pop();                      cyc(1, 0, 8'h21, 0); endtask
    task automatic rd(input logic [7:0] a);    cyc(1, 0, a, 0);     endtask
    task automatic idle();                     cyc(0, 0, 8'h00, 0); endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_dout"}, dout, 32'h0);
        check_val({tag, "_cnt"}, 32'(fifo_cnt), 32'h0);
        check_val({tag, "_flag"}, 32'(fifo_flag), 32'h0);
        check_val({tag, "_irq"}, 32'(irq), 32'h0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Status after reset: empty only
        rd(8'h20); idle();

        // Fill, overflow, drain in order
        for (int i = 1; i <= 5; i++) push(32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) pop();
        idle();

        // Underflow and sticky clear-on-read
        pop(); idle();
        rd(8'h20); rd(8'h20);

        // Threshold interrupt
        cyc(1, 1, 8'h22, 32'h302);
        rd(8'h22);
        for (int i = 1; i <= 3; i++) push(32'hB0 + 32'(i));
        idle();
        pop(); idle();
        pop(); pop();

        // Flush discards contents; new data is not stale
        for (int i = 1; i <= 3; i++) push(32'hC0 + 32'(i));
        cyc(1, 1, 8'h22, 32'h001);
        rd(8'h23); rd(8'h20);
        push(32'hD1); pop(); pop();

        // Out-of-range accesses and writes to read-only registers
        rd(8'h24); cyc(1, 1, 8'h1F, 32'h55); cyc(1, 1, 8'h20, 32'hFF); rd(8'h20);
        cyc(0, 0, 8'h20, 0);

        // Pointer wrap with interleaved pops
        push(32'hE1); push(32'hE2); pop(); push(32'hE3); push(32'hE4); pop();
        push(32'hE5); pop(); push(32'hE6); pop(); rd(8'h23);

        // Reset in the middle of a push
        @(negedge clk);
        check_pending();
        sel = 1'b1; wr = 1'b1; address = 8'h21; din = 32'hDEAD;
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        sbq.delete();
        @(negedge clk);
        sel = 1'b0; wr = 1'b0;
        reset_n = 1'b1;
        rd(8'h20); pop(); push(32'hF1); pop();

        @(negedge clk);
        check_pending();
        sel = 1'b0;
        @(negedge clk);
        check_pending();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
